// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_ctrl_pkg: shared states and constants for ALU unit sharing   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package alu_ctrl_pkg;

  localparam int DATA_W = 64;

  // Quotient returned when a division cannot produce a real result
  localparam logic [DATA_W-1:0] ERR_Q = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_div_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: one-hot round-robin grant, search from ptr upward    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic             lo_hit;
  logic             hi_hit;

  // Lowest request at/above ptr wins; otherwise wrap to the lowest overall
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        lo_hit = 1'b1;
      end
      if (req[i] && (i >= int'(ptr))) begin
        hi_idx = IDX_W'(i);
        hi_hit = 1'b1;
      end
    end
  end

  assign grant_idx = hi_hit ? hi_idx : lo_idx;
  assign valid     = lo_hit;

  always_comb begin
    grant = '0;
    if (lo_hit) grant[grant_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/alu_div_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_div_arbiter: round-robin sharing of one iterative divider    |
// | Rev 1.0 - option macro ALU_DIV_ZERO_BYPASS_EN (x/0 bypass)       |
// +------------------------------------------------------------------+
module alu_div_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_busy,
  input  logic [DATA_W-1:0]         div_q,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_q,
  output logic                      resp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [ID_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;
  logic [DATA_W-1:0]  sel_dividend;
  logic [DATA_W-1:0]  sel_divisor;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timed_out;
  logic               bypass;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign sel_dividend = req_dividend[arb_idx*DATA_W +: DATA_W];
  assign sel_divisor  = req_divisor[arb_idx*DATA_W +: DATA_W];
  assign ptr_nxt      = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
  assign timed_out    = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign div_dividend = op_a;
  assign div_divisor  = op_b;

`ifdef ALU_DIV_ZERO_BYPASS_EN
  assign bypass = (sel_divisor == '0);
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are forced low while reset is held so nothing leaks mid-reset
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            req_ready = arb_grant;
            state_nxt = bypass ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          div_start = 1'b1;
          state_nxt = ARM;
        end
        ARM:  state_nxt = WAIT;
        WAIT: begin
          if (!div_busy || timed_out) state_nxt = RESP;
        end
        RESP: begin
          resp_valid = 1'b1;
          if (resp_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      wait_cnt <= '0;
      resp_id  <= '0;
      resp_q   <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            ptr     <= ptr_nxt;
            op_a    <= sel_dividend;
            op_b    <= sel_divisor;
            resp_id <= arb_idx;
            if (bypass) begin
              resp_q   <= ERR_Q;
              resp_err <= 1'b1;
            end
          end
        end
        ARM: wait_cnt <= '0;
        // A timed-out divider keeps running; its late result is simply ignored
        WAIT: begin
          if (!div_busy) begin
            resp_q   <= div_q;
            resp_err <= 1'b0;
          end else if (timed_out) begin
            resp_q   <= ERR_Q;
            resp_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
